rf_mp_hl: RTL and testbench

RF_MP_HL -- requirements
Module: rf_mp_hl

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 32 +++
 rtl/rf_mp_hl.sv | 101 ++++++++++
 tb/tb_rf_mp_hl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the multi-port register file: write-mode encodings
// and default geometry.
package rf_pkg;

  localparam int DW_DEF  = 32;
  localparam int AW_DEF  = 4;
  localparam int NRD_DEF = 3;

  localparam logic [1:0] WM_FULL = 2'b00;
  localparam logic [1:0] WM_LO   = 2'b01;
  localparam logic [1:0] WM_HI   = 2'b10;
  localparam logic [1:0] WM_NONE = 2'b11;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking. busy_nxt is the post-update view so the read
// path can forward it in the same cycle; a set wins over a clear to the
// same entry.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [AW-1:0]       set_addr,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_addr,
  output logic [2**AW-1:0]    busy_q,
  output logic [2**AW-1:0]    busy_nxt
);

  // next busy vector: clear first, then set so alloc wins on collision
  always_comb begin
    busy_nxt = busy_q;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
  end

  // busy register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

endmodule

// File: rtl/rf_mp_hl.sv
// Multi-port register file with half-word write merge, same-cycle write
// bypass onto registered read ports, and per-register busy bits.
module rf_mp_hl
  import rf_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [1:0]        wmode,
  input  logic [DW-1:0]     wdata,
  input  logic              alloc,
  input  logic [AW-1:0]     alloc_addr
);

  localparam int HW    = DW / 2;
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     merged;
  logic              eff_we;
  logic              alloc_en;
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_nxt;
  logic [NRD*DW-1:0] rdata_nxt;
  logic [NRD-1:0]    rbusy_nxt;

  assign eff_we   = we && (wmode != WM_NONE) && !((ZERO_REG != 0) && (waddr == '0));
  assign alloc_en = alloc && !((ZERO_REG != 0) && (alloc_addr == '0));

  // merge the write data with the current contents for half-word modes
  always_comb begin
    merged = wdata;
    case (wmode)
      WM_LO:   merged = {mem[waddr][DW-1:HW], wdata[HW-1:0]};
      WM_HI:   merged = {wdata[DW-1:HW], mem[waddr][HW-1:0]};
      default: merged = wdata;
    endcase
  end

  rf_scoreboard #(.AW(AW)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (alloc_en),
    .set_addr (alloc_addr),
    .clr_en   (eff_we),
    .clr_addr (waddr),
    .busy_q   (busy_q),
    .busy_nxt (busy_nxt)
  );

  // storage update; reset clears every entry so no write survives it
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (eff_we) begin
      mem[waddr] <= merged;
    end
  end

  // read-port values as they will look after this edge (write bypass)
  always_comb begin
    rdata_nxt = '0;
    rbusy_nxt = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] ra;
      ra = raddr[k*AW +: AW];
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rdata_nxt[k*DW +: DW] = '0;
        rbusy_nxt[k]          = 1'b0;
      end else begin
        rdata_nxt[k*DW +: DW] = (eff_we && (ra == waddr)) ? merged : mem[ra];
        rbusy_nxt[k]          = busy_nxt[ra];
      end
    end
  end

  // registered read outputs, held while re is low
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
      rbusy <= '0;
    end else if (re) begin
      rdata <= rdata_nxt;
      rbusy <= rbusy_nxt;
    end
  end

  logic unused_busy_q;
  assign unused_busy_q = ^busy_q;

endmodule

// File: tb/tb_rf_mp_hl.sv
// Bench for rf_mp_hl: two instances (ZERO_REG 0 and 1) share stimulus;
// directed table rows carry hand-derived expectations, a random phase
// uses a small reference model. Expectations go through a queue.
module tb_rf_mp_hl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        re = 1'b0;
  logic [11:0] raddr = '0;
  logic        we = 1'b0;
  logic [3:0]  waddr = '0;
  logic [1:0]  wmode = 2'b11;
  logic [31:0] wdata = '0;
  logic        alloc = 1'b0;
  logic [3:0]  alloc_addr = '0;

  logic [95:0] rdata0, rdata1;
  logic [2:0]  rbusy0, rbusy1;

  always #5 clk = ~clk;

  rf_mp_hl #(.DW(32), .AW(4), .NRD(3), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset(reset), .re(re), .raddr(raddr), .rdata(rdata0),
    .rbusy(rbusy0), .we(we), .waddr(waddr), .wmode(wmode), .wdata(wdata),
    .alloc(alloc), .alloc_addr(alloc_addr));

  rf_mp_hl #(.DW(32), .AW(4), .NRD(3), .ZERO_REG(1)) dut1 (
    .clk(clk), .reset(reset), .re(re), .raddr(raddr), .rdata(rdata1),
    .rbusy(rbusy1), .we(we), .waddr(waddr), .wmode(wmode), .wdata(wdata),
    .alloc(alloc), .alloc_addr(alloc_addr));

  typedef struct {
    logic        rst, re, we;
    logic [1:0]  wm;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        al;
    logic [3:0]  aa;
    logic [11:0] ra;
    logic [95:0] xd0;
    logic [2:0]  xb0;
    logic [95:0] xd1;
    logic [2:0]  xb1;
  } vec_t;

  typedef struct {
    string       name;
    logic [95:0] xd0;
    logic [2:0]  xb0;
    logic [95:0] xd1;
    logic [2:0]  xb1;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  logic [31:0] mm [2][16];
  logic        bb [2][16];
  logic [95:0] md [2];
  logic [2:0]  mb [2];

  function automatic vec_t mk(logic rst, logic r, logic w, logic [1:0] wm,
                              logic [3:0] wa, logic [31:0] wd, logic al,
                              logic [3:0] aa, logic [11:0] ra,
                              logic [95:0] xd, logic [2:0] xb);
    vec_t v;
    v.rst = rst; v.re = r; v.we = w; v.wm = wm; v.wa = wa; v.wd = wd;
    v.al = al; v.aa = aa; v.ra = ra;
    v.xd0 = xd; v.xb0 = xb; v.xd1 = xd; v.xb1 = xb;
    return v;
  endfunction

  task automatic check(string nm, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    for (int z = 0; z < 2; z++) begin
      if (!reset) begin
        for (int i = 0; i < 16; i++) begin
          mm[z][i] = '0;
          bb[z][i] = 1'b0;
        end
        md[z] = '0;
        mb[z] = '0;
      end else begin
        logic eff;
        logic [31:0] mv;
        eff = we && (wmode != 2'b11) && !(z == 1 && waddr == 4'd0);
        if (wmode == 2'b00)      mv = wdata;
        else if (wmode == 2'b01) mv = {mm[z][waddr][31:16], wdata[15:0]};
        else                     mv = {wdata[31:16], mm[z][waddr][15:0]};
        if (eff) begin
          mm[z][waddr] = mv;
          bb[z][waddr] = 1'b0;
        end
        if (alloc && !(z == 1 && alloc_addr == 4'd0)) bb[z][alloc_addr] = 1'b1;
        if (re) begin
          for (int k = 0; k < 3; k++) begin
            logic [3:0] a;
            a = raddr[k*4 +: 4];
            if (z == 1 && a == 4'd0) begin
              md[z][k*32 +: 32] = '0;
              mb[z][k] = 1'b0;
            end else begin
              md[z][k*32 +: 32] = mm[z][a];
              mb[z][k] = bb[z][a];
            end
          end
        end
      end
    end
  endtask

  // drive one cycle, queue its expectation, compare after the edge
  task automatic cycle(vec_t v, bit use_model, string nm);
    exp_t e;
    reset = v.rst; re = v.re; we = v.we; wmode = v.wm; waddr = v.wa;
    wdata = v.wd; alloc = v.al; alloc_addr = v.aa; raddr = v.ra;
    model_step();
    e.name = nm;
    if (use_model) begin
      e.xd0 = md[0]; e.xb0 = mb[0]; e.xd1 = md[1]; e.xb1 = mb[1];
    end else begin
      e.xd0 = v.xd0; e.xb0 = v.xb0; e.xd1 = v.xd1; e.xb1 = v.xb1;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      check({e.name, ".rdata0"}, rdata0, e.xd0);
      check({e.name, ".rbusy0"}, {93'd0, rbusy0}, {93'd0, e.xb0});
      check({e.name, ".rdata1"}, rdata1, e.xd1);
      check({e.name, ".rbusy1"}, {93'd0, rbusy1}, {93'd0, e.xb1});
    end
  endtask

  vec_t tbl[15];

  initial begin
    vec_t v;
    // rst re we wm wa wd al aa ra{p2,p1,p0} xd{p2,p1,p0} xb
    tbl[0]  = mk(0,1,1,2'b00,4'd9,32'h55,1,4'd9,{4'd5,4'd5,4'd5}, 96'h0, 3'b000);
    tbl[1]  = mk(1,1,0,2'b00,4'd0,32'h0,0,4'd0,{4'd5,4'd5,4'd5}, 96'h0, 3'b000);
    tbl[2]  = mk(1,0,1,2'b00,4'd3,32'h12345678,0,4'd0,{4'd3,4'd3,4'd3}, 96'h0, 3'b000);
    tbl[3]  = mk(1,0,1,2'b01,4'd3,32'hFFFFAAAA,0,4'd0,{4'd3,4'd3,4'd3}, 96'h0, 3'b000);
    tbl[4]  = mk(1,1,0,2'b00,4'd0,32'h0,0,4'd0,{4'd3,4'd3,4'd3},
                 {32'h1234AAAA,32'h1234AAAA,32'h1234AAAA}, 3'b000);
    tbl[5]  = mk(1,1,1,2'b10,4'd3,32'hBBBB0000,0,4'd0,{4'd3,4'd5,4'd3},
                 {32'hBBBBAAAA,32'h0,32'hBBBBAAAA}, 3'b000);
    tbl[6]  = mk(1,1,1,2'b00,4'd7,32'hDEADBEEF,0,4'd0,{4'd0,4'd3,4'd7},
                 {32'h0,32'hBBBBAAAA,32'hDEADBEEF}, 3'b000);
    tbl[7]  = mk(1,0,0,2'b00,4'd0,32'h0,1,4'd4,{4'd4,4'd4,4'd4},
                 {32'h0,32'hBBBBAAAA,32'hDEADBEEF}, 3'b000);
    tbl[8]  = mk(1,1,0,2'b00,4'd0,32'h0,0,4'd0,{4'd4,4'd7,4'd4},
                 {32'h0,32'hDEADBEEF,32'h0}, 3'b101);
    tbl[9]  = mk(1,1,1,2'b01,4'd4,32'hFFFF1111,0,4'd0,{4'd4,4'd4,4'd4},
                 {32'h1111,32'h1111,32'h1111}, 3'b000);
    tbl[10] = mk(1,1,1,2'b00,4'd4,32'hCAFEF00D,1,4'd4,{4'd4,4'd4,4'd4},
                 {32'hCAFEF00D,32'hCAFEF00D,32'hCAFEF00D}, 3'b111);
    tbl[11] = mk(1,1,1,2'b11,4'd4,32'h00000001,0,4'd0,{4'd4,4'd4,4'd4},
                 {32'hCAFEF00D,32'hCAFEF00D,32'hCAFEF00D}, 3'b111);
    tbl[12] = mk(1,1,1,2'b00,4'd6,32'h66,1,4'd5,{4'd4,4'd6,4'd5},
                 {32'hCAFEF00D,32'h66,32'h0}, 3'b101);
    tbl[13] = mk(0,1,1,2'b00,4'd9,32'h55,1,4'd9,{4'd4,4'd6,4'd9}, 96'h0, 3'b000);
    tbl[14] = mk(1,1,0,2'b00,4'd0,32'h0,0,4'd0,{4'd5,4'd4,4'd9}, 96'h0, 3'b000);

    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) cycle(tbl[i], 1'b0, $sformatf("row%0d", i));

    // address-0 handling differs between the two instances
    v = mk(1,1,1,2'b00,4'd0,32'hFFFFFFFF,1,4'd0,{4'd0,4'd0,4'd0},
           {3{32'hFFFFFFFF}}, 3'b111);
    v.xd1 = '0; v.xb1 = '0;
    cycle(v, 1'b0, "zr_wr_alloc");
    v = mk(1,1,0,2'b00,4'd0,32'h0,0,4'd0,{4'd0,4'd0,4'd0},
           {3{32'hFFFFFFFF}}, 3'b111);
    v.xd1 = '0; v.xb1 = '0;
    cycle(v, 1'b0, "zr_read");
    v = mk(1,0,1,2'b00,4'd2,32'h22,0,4'd0,{4'd0,4'd0,4'd0},
           {3{32'hFFFFFFFF}}, 3'b111);
    v.xd1 = '0; v.xb1 = '0;
    cycle(v, 1'b0, "zr_wr_r2");
    v = mk(1,1,1,2'b11,4'd2,32'h99,0,4'd0,{4'd0,4'd2,4'd2},
           {32'hFFFFFFFF,32'h22,32'h22}, 3'b100);
    v.xd1 = {32'h0,32'h22,32'h22}; v.xb1 = 3'b000;
    cycle(v, 1'b0, "wm11_r2");

    for (int n = 0; n < 300; n++) begin
      v.rst = ($urandom_range(0, 49) != 0);
      v.re  = $urandom_range(0, 3) != 0;
      v.we  = $urandom_range(0, 1) == 1;
      v.wm  = 2'($urandom_range(0, 3));
      v.wa  = 4'($urandom_range(0, 7));
      v.wd  = $urandom;
      v.al  = $urandom_range(0, 3) == 0;
      v.aa  = 4'($urandom_range(0, 7));
      v.ra  = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
               4'($urandom_range(0, 7))};
      cycle(v, 1'b1, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
